// File: rtl/pipeline_stage_skid_if.sv
// Purpose:
//   Valid/ready stream bundle used on both sides of pipeline_stage_skid.
//   One stream entry is made of a data bundle, a control bundle and a
//   destination-register index. All three always travel together.
// Signals:
//   valid  producer has an entry on the bus this cycle
//   ready  consumer can take the entry this cycle
//   data   payload bundle (DATA_W bits)
//   ctrl   control bundle (CTRL_W bits)
//   rd     destination-register index (RD_W bits)
// Modports:
//   master  the producer side; drives valid/data/ctrl/rd and reads ready
//   slave   the consumer side; reads valid/data/ctrl/rd and drives ready
interface pipeline_stage_skid_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 7,
    parameter int RD_W   = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;

    modport master (output valid, output data, output ctrl, output rd, input ready);
    modport slave  (input valid, input data, input ctrl, input rd, output ready);
endinterface

// File: rtl/pipeline_stage_skid.sv
// Purpose:
//   Parametrised valid/ready pipeline stage. It holds up to two entries
//   (head plus skid) when SKID=1, and a single entry when SKID=0. Entries
//   leave strictly in arrival order.
//   A synchronous flush empties the stage. While the stage is empty it
//   presents the NOP control value with zero data and a zero destination
//   index. A saturating counter records the cycles in which the head was
//   stalled by the downstream stage.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; has priority over flush
//   flush       drop every held entry, together with any entry offered
//               in the same cycle
//   upstream    slave side of the incoming stream; ready is driven here
//   downstream  master side of the outgoing stream; it is fed by the head
//               register
//   occupancy   number of held entries (0..2)
//   stall_cnt   cycles with downstream.valid && !downstream.ready && !flush;
//               it saturates at its maximum value
module pipeline_stage_skid #(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 7,
    parameter int                RD_W     = 5,
    parameter logic [CTRL_W-1:0] NOP_CTRL = 7'b0001000,
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipeline_stage_skid_if.slave  upstream,
    pipeline_stage_skid_if.master downstream,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    // Contents of a vacant register. The head drives the outputs directly,
    // so clearing it to this value whenever it empties keeps stale payload
    // off the bus.
    localparam entry_t         NOP_ENTRY = '{data: '0, ctrl: NOP_CTRL, rd: '0};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    assign in_entry = '{data: upstream.data, ctrl: upstream.ctrl, rd: upstream.rd};

    // In two-entry mode, ready depends only on registered state, so
    // downstream back-pressure never reaches upstream combinationally.
    // In single-entry mode, a full stage can still take an entry in the
    // same cycle that the head leaves. That needs a pass-through from
    // downstream.ready.
    always_comb begin
        if (SKID) begin
            upstream.ready = !rst && (state != ST_SKID);
        end else begin
            upstream.ready = !rst && ((state == ST_EMPTY) || downstream.ready);
        end
    end

    assign accept = upstream.valid && upstream.ready;
    assign pop    = downstream.valid && downstream.ready;

    assign downstream.valid = (state != ST_EMPTY);
    assign downstream.data  = main_q.data;
    assign downstream.ctrl  = main_q.ctrl;
    assign downstream.rd    = main_q.rd;

    // Occupancy is decoded from the state.
    always_comb begin
        case (state)
            ST_EMPTY: occupancy = 2'd0;
            ST_FULL:  occupancy = 2'd1;
            ST_SKID:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    // Entry storage and occupancy state. Reset and flush both empty the
    // stage. An entry offered in a flush cycle is discarded.
    // The accept-without-pop move into ST_SKID can only happen when SKID=1.
    // In single-entry mode, a full stage is ready only while the head is
    // being popped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= ST_EMPTY;
            main_q <= NOP_ENTRY;
            skid_q <= NOP_ENTRY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q <= in_entry;
                        state  <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        main_q <= in_entry;
                    end else if (accept && SKID) begin
                        skid_q <= in_entry;
                        state  <= ST_SKID;
                    end else if (pop) begin
                        main_q <= NOP_ENTRY;
                        state  <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        main_q <= skid_q;
                        skid_q <= NOP_ENTRY;
                        state  <= ST_FULL;
                    end
                end
                default: begin
                    main_q <= NOP_ENTRY;
                    skid_q <= NOP_ENTRY;
                    state  <= ST_EMPTY;
                end
            endcase
        end
    end

    // Stall counter for performance debug. Only reset clears it. A flush
    // cycle does not count as a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (downstream.valid && !downstream.ready && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Purpose:
//   Self-checking bench for pipeline_stage_skid. It uses three instances:
//     dut_m  two-entry mode with a 16-bit counter (vector table, random)
//     dut_s  single-entry mode (hand sequence, random)
//     dut_t  two-entry mode with a 4-bit counter (saturation, random)
//   The reference model is a plain bounded FIFO of rd values per instance.
//   Data and ctrl are derived from rd, so one value describes a whole entry.
module tb_pipeline_stage_skid;

    localparam logic [6:0] NOP = 7'b0001000;

    logic        clk;
    logic        rst_m, rst_s, rst_t;
    logic        flush_m, flush_s, flush_t;
    logic [1:0]  occ_m, occ_s, occ_t;
    logic [15:0] stall_m, stall_s;
    logic [3:0]  stall_t;

    int total;
    int bad;

    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) up_m ();
    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) dn_m ();
    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) up_s ();
    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) dn_s ();
    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) up_t ();
    pipeline_stage_skid_if #(.DATA_W(96), .CTRL_W(7), .RD_W(5)) dn_t ();

    pipeline_stage_skid #(.SKID(1'b1), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst_m), .flush(flush_m),
        .upstream(up_m), .downstream(dn_m),
        .occupancy(occ_m), .stall_cnt(stall_m)
    );

    pipeline_stage_skid #(.SKID(1'b0), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst_s), .flush(flush_s),
        .upstream(up_s), .downstream(dn_s),
        .occupancy(occ_s), .stall_cnt(stall_s)
    );

    pipeline_stage_skid #(.SKID(1'b1), .CNT_W(4)) dut_t (
        .clk(clk), .rst(rst_t), .flush(flush_t),
        .upstream(up_t), .downstream(dn_t),
        .occupancy(occ_t), .stall_cnt(stall_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] mk_data(input logic [4:0] r);
        return {27'h1A5A5A5, r, 27'h0123456, r, 27'h3654321, r};
    endfunction

    function automatic logic [6:0] mk_ctrl(input logic [4:0] r);
        return {2'b10, r};
    endfunction

    // Reference model: a bounded FIFO per instance plus a saturating stall count.
    int mb[3][2];
    int mocc[3];
    int mcnt[3];
    int mcap[3];
    int mmax[3];

    function automatic bit m_ready(input int d, input bit r, input bit ordy);
        if (r) return 1'b0;
        if (mcap[d] == 2) return (mocc[d] < 2);
        return (mocc[d] == 0) || ordy;
    endfunction

    task automatic model_step(input int d, input bit r, input bit fl, input bit iv, input int rd, input bit ordy);
        bit acc;
        bit pp;
        acc = iv && m_ready(d, r, ordy);
        pp  = (mocc[d] > 0) && ordy;
        if (r) begin
            mocc[d] = 0;
            mcnt[d] = 0;
        end else if (fl) begin
            mocc[d] = 0;
        end else begin
            if ((mocc[d] > 0) && !ordy && (mcnt[d] < mmax[d])) mcnt[d] = mcnt[d] + 1;
            if (pp) begin
                mb[d][0] = mb[d][1];
                mocc[d]  = mocc[d] - 1;
            end
            if (acc) begin
                mb[d][mocc[d]] = rd;
                mocc[d]        = mocc[d] + 1;
            end
        end
    endtask

    // Drive one cycle of inputs into the selected instance.
    task automatic applyStimulus(input int d, input bit r, input bit fl, input bit iv, input int rd, input bit ordy);
        logic [4:0] r5;
        r5 = 5'(rd);
        case (d)
            0: begin
                rst_m = r; flush_m = fl; up_m.valid = iv; up_m.rd = r5;
                up_m.data = mk_data(r5); up_m.ctrl = mk_ctrl(r5); dn_m.ready = ordy;
            end
            1: begin
                rst_s = r; flush_s = fl; up_s.valid = iv; up_s.rd = r5;
                up_s.data = mk_data(r5); up_s.ctrl = mk_ctrl(r5); dn_s.ready = ordy;
            end
            default: begin
                rst_t = r; flush_t = fl; up_t.valid = iv; up_t.rd = r5;
                up_t.data = mk_data(r5); up_t.ctrl = mk_ctrl(r5); dn_t.ready = ordy;
            end
        endcase
    endtask

    task automatic compare(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Compare every output of one instance against the expected entry view.
    task automatic checkOutput(input string nm, input int d, input bit e_ir, input bit e_ov,
                               input int e_rd, input int e_occ, input int e_cnt);
        logic        ir, ov;
        logic [95:0] od;
        logic [6:0]  oc;
        logic [4:0]  ord;
        logic [1:0]  occ;
        logic [15:0] cnt;
        logic [4:0]  er;
        case (d)
            0: begin
                ir = up_m.ready; ov = dn_m.valid; od = dn_m.data; oc = dn_m.ctrl;
                ord = dn_m.rd; occ = occ_m; cnt = stall_m;
            end
            1: begin
                ir = up_s.ready; ov = dn_s.valid; od = dn_s.data; oc = dn_s.ctrl;
                ord = dn_s.rd; occ = occ_s; cnt = stall_s;
            end
            default: begin
                ir = up_t.ready; ov = dn_t.valid; od = dn_t.data; oc = dn_t.ctrl;
                ord = dn_t.rd; occ = occ_t; cnt = {12'h000, stall_t};
            end
        endcase
        er = 5'(e_rd);
        compare({nm, ".in_ready"},  96'(ir),  96'(e_ir));
        compare({nm, ".out_valid"}, 96'(ov),  96'(e_ov));
        compare({nm, ".out_rd"},    96'(ord), e_ov ? 96'(er) : 96'h0);
        compare({nm, ".out_data"},  od,       e_ov ? mk_data(er) : 96'h0);
        compare({nm, ".out_ctrl"},  96'(oc),  e_ov ? 96'(mk_ctrl(er)) : 96'(NOP));
        compare({nm, ".occupancy"}, 96'(occ), 96'(e_occ));
        compare({nm, ".stall_cnt"}, 96'(cnt), 96'(e_cnt));
    endtask

    typedef struct {
        bit rst;
        bit flush;
        bit iv;
        int rd;
        bit ordy;
        bit e_ir;
        bit e_ov;
        int e_rd;
        int e_occ;
        int e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input bit r, input bit fl, input bit iv, input int rd, input bit ordy,
                                    input bit e_ir, input bit e_ov, input int e_rd, input int e_occ, input int e_cnt);
        vec_t v;
        v = '{r, fl, iv, rd, ordy, e_ir, e_ov, e_rd, e_occ, e_cnt};
        vecs.push_back(v);
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        mcap  = '{2, 1, 2};
        mmax  = '{65535, 65535, 15};

        // Each row gives the inputs of one cycle and the outputs seen in
        // that cycle, before its clock edge.
        //        rst fl iv rd ordy | ir ov rd occ cnt
        // streaming rd 1..8 with downstream always ready
        add_vec(0, 0, 1, 1, 1,   1, 0, 0, 0, 0);
        for (int k = 2; k <= 8; k++) add_vec(0, 0, 1, k, 1,   1, 1, k - 1, 1, 0);
        add_vec(0, 0, 0, 0, 1,   1, 1, 8, 1, 0);
        add_vec(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        // back-pressure: 3 and 4 are accepted, 5 waits upstream until the skid drains
        add_vec(0, 0, 1, 3, 0,   1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 4, 0,   1, 1, 3, 1, 0);
        add_vec(0, 0, 1, 5, 0,   0, 1, 3, 2, 1);
        add_vec(0, 0, 1, 5, 0,   0, 1, 3, 2, 2);
        add_vec(0, 0, 1, 5, 1,   0, 1, 3, 2, 3);
        add_vec(0, 0, 1, 5, 1,   1, 1, 4, 1, 3);
        add_vec(0, 0, 0, 0, 1,   1, 1, 5, 1, 3);
        add_vec(0, 0, 0, 0, 0,   1, 0, 0, 0, 3);
        // flush while two entries are held; rd=9 is offered in the flush cycle
        add_vec(0, 0, 1, 10, 0,  1, 0, 0, 0, 3);
        add_vec(0, 0, 1, 11, 0,  1, 1, 10, 1, 3);
        add_vec(0, 1, 1, 9, 0,   0, 1, 10, 2, 4);
        add_vec(0, 0, 0, 0, 1,   1, 0, 0, 0, 4);
        add_vec(0, 0, 0, 0, 1,   1, 0, 0, 0, 4);
        // reset while two entries are held and stall_cnt is 5
        add_vec(0, 0, 1, 12, 0,  1, 0, 0, 0, 4);
        add_vec(0, 0, 1, 13, 0,  1, 1, 12, 1, 4);
        add_vec(1, 0, 1, 14, 0,  0, 1, 12, 2, 5);
        add_vec(0, 0, 0, 0, 0,   1, 0, 0, 0, 0);

        for (int d = 0; d < 3; d++) applyStimulus(d, 1, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].rd, vecs[i].ordy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), 0, vecs[i].e_ir, vecs[i].e_ov,
                        vecs[i].e_rd, vecs[i].e_occ, vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Single-entry mode: a full stage takes rd=7 in the same cycle that downstream pops.
        applyStimulus(1, 0, 0, 1, 6, 0);
        @(negedge clk); checkOutput("single0", 1, 1, 0, 0, 0, 0); @(posedge clk); #1;
        applyStimulus(1, 0, 0, 1, 7, 0);
        @(negedge clk); checkOutput("single1", 1, 0, 1, 6, 1, 0); @(posedge clk); #1;
        applyStimulus(1, 0, 0, 1, 7, 1);
        @(negedge clk); checkOutput("single2", 1, 1, 1, 6, 1, 1); @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("single3", 1, 0, 1, 7, 1, 1); @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 0, 1);
        @(negedge clk); checkOutput("single4", 1, 1, 1, 7, 1, 2); @(posedge clk); #1;
        @(negedge clk); checkOutput("single5", 1, 1, 0, 0, 0, 2); @(posedge clk); #1;

        // Saturation: the 4-bit counter stops at 15 after 20 stalled cycles.
        for (int i = 0; i <= 22; i++) begin
            applyStimulus(2, 0, 0, (i == 0), 21, 0);
            @(negedge clk);
            checkOutput($sformatf("sat%0d", i), 2, 1, (i > 0), 21, (i > 0) ? 1 : 0,
                        (i == 0) ? 0 : ((i - 1 > 15) ? 15 : i - 1));
            @(posedge clk);
            #1;
        end

        // Random traffic on all three instances against the FIFO model.
        // Cycle 0 is a reset, which aligns every instance with the model.
        for (int i = 0; i < 400; i++) begin
            bit r, fl, iv, ordy;
            int rd;
            r    = (i == 0) || ($urandom_range(0, 49) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) != 0);
            rd   = int'($urandom_range(0, 31));
            for (int d = 0; d < 3; d++) applyStimulus(d, r, fl, iv, rd, ordy);
            @(negedge clk);
            if (i > 0) begin
                for (int d = 0; d < 3; d++) begin
                    checkOutput($sformatf("rnd%0d.d%0d", i, d), d, m_ready(d, r, ordy), (mocc[d] > 0),
                                (mocc[d] > 0) ? mb[d][0] : 0, mocc[d], mcnt[d]);
                end
            end
            @(posedge clk);
            for (int d = 0; d < 3; d++) model_step(d, r, fl, iv, rd, ordy);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
Generic, parametrised pipeline stage register that replaces the fixed per-boundary registers (EXE->MEM and others) with a valid/ready stage. It carries a data bundle, a control bundle and a destination-register index. It supports a 2-entry skid buffer, so back-pressure never forms a combinational ready path, and a synchronous flush that injects a configurable NOP. It also provides a saturating stall-cycle counter for performance debug.

Parameters:
DATA_W, 96, width of payload data bundle (e.g. ALUResult, WriteData, PCPlus4 concatenated)
CTRL_W, 7, width of control bundle (e.g. RegWrite, ResultSrc, AddrMode[3:0], WD3Src)
RD_W, 5, width of destination-register index
NOP_CTRL, 7'b0001000, control value presented while the stage holds no valid entry; must have RegWrite=0
SKID, 1, 1 = two-entry skid mode; 0 = single-entry mode
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries; sampled on clk
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
in_rd  in  RD_W  upstream destination index
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head this cycle
out_data  out  DATA_W  head data; 0 when !out_valid
out_ctrl  out  CTRL_W  head control; NOP_CTRL when !out_valid
out_rd  out  RD_W  head destination index; 0 when !out_valid
occupancy  out  2  number of held entries (0..2)
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- accept = in_valid && in_ready; pop = out_valid && out_ready. All state updates happen on the rising clk edge.
- Storage: main register (head, drives outputs) and skid register (SKID=1 only). Delivery is strictly FIFO. Data, ctrl and rd are always stored together as one entry.
- States (SKID=1): EMPTY (occ 0), FULL (occ 1), SKID (occ 2).
  - EMPTY: accept -> FULL, main<=in.
  - FULL: accept&&pop -> FULL, main<=in. accept&&!pop -> SKID, skid<=in. !accept&&pop -> EMPTY. Otherwise hold.
  - SKID: in_ready=0. pop -> FULL, main<=skid. Otherwise hold.
- SKID=1: in_ready = !rst && state!=SKID. It depends on registered state only, with no path from out_ready. Latency in->out is 1 cycle.
- SKID=0: states EMPTY/FULL only. in_ready = !rst && (state==EMPTY || out_ready), which is a combinational pass-through. accept&&pop -> FULL with main<=in. occupancy never exceeds 1.
- out_valid = (state!=EMPTY). When out_valid=0: out_ctrl=NOP_CTRL, out_data=0, out_rd=0. No stale payload is ever visible.
- flush=1: next state EMPTY and both registers cleared. Flush has priority over accept and pop in the same cycle; the offered input is dropped. A downstream pop in the flush cycle still counts as consumed by downstream logic.
- rst=1: next state EMPTY, registers cleared, stall_cnt<=0. in_ready=0 during any cycle rst is high, and inputs offered then are dropped. Reset mid-SKID discards both entries.
- rst has priority over flush.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready && !flush. It saturates at 2^CNT_W-1 and is cleared only by rst.
- Outputs after reset: out_valid=0, out_ctrl=NOP_CTRL, out_data=0, out_rd=0, occupancy=0, stall_cnt=0. in_ready=1 from the first cycle after rst deasserts.
- No entry is lost or duplicated under any combination of in_valid, out_ready and flush.

Test Plan:
- Streaming, SKID=1: out_ready=1; drive entries rd=1..8, in_valid every cycle.
  - out_rd sequence is 1..8, each 1 cycle after accept.
  - in_ready stays 1; occupancy stays ≤1; stall_cnt=0.
- Back-pressure:
  - Setup: out_ready=0; drive rd=3, then rd=4, then rd=5.
  - Expected: occupancy goes 1 then 2; in_ready=0 after the second accept; rd=5 is held upstream.
  - Release: raise out_ready. Output order is 3, 4, 5. stall_cnt equals the number of stalled cycles with out_valid high.
- Flush in SKID state: with occupancy=2, assert flush and in_valid (rd=9) in the same cycle.
  - Next cycle: occupancy=0, out_valid=0, out_ctrl=NOP_CTRL, out_data=0.
  - rd=9 never appears at the output.
- Reset mid-operation: assert rst for 1 cycle with occupancy=2 and stall_cnt=5.
  - During the rst cycle: in_ready=0.
  - Next cycle: all outputs at reset values, and in_ready=1.
- Single-entry mode, SKID=0: hold occupancy=1 with out_ready=0 (in_ready=0), then raise out_ready with in_valid=1, rd=7.
  - in_ready=1 in the same cycle.
  - rd=7 replaces the head next cycle; occupancy stays 1.
- Counter saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and held.
